// File: rtl/alu_simd_mc.sv
// alu_simd_mc: LANES x N-bit signed SIMD ALU with valid/ready handshakes.
// Add/sub/mul/or/and/copy-b take 1 cycle; div/mod use an N+1 cycle divider.
// Ports: clk, rst_n (sync, active-low), in_valid/in_ready, ctrl, a, b,
//        out_valid/out_ready, result, flags ({neg,zero,carry,ovf}/lane), dz.
// Optional: define ALU_SAT_EN to saturate add/sub/mul on signed overflow.
module alu_simd_mc #(
    parameter int N     = 8,
    parameter int LANES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         ctrl,
    input  logic [LANES*N-1:0] a,
    input  logic [LANES*N-1:0] b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LANES*N-1:0] result,
    output logic [LANES*4-1:0] flags,
    output logic [LANES-1:0]   dz
);
    localparam int CW = $clog2(N + 1);
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_MOD = 4'b0100;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_CPB = 4'b0110;
    localparam logic [3:0] OP_DIV = 4'b1000;
    localparam logic [N-1:0] MAXV = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] MINV = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               div_q, div_d;
    logic [LANES*N-1:0] a_q, a_d, b_q, b_d;
    logic [LANES*N-1:0] dq_q, dq_d, rm_q, rm_d, dv_q, dv_d;
    logic [LANES*N-1:0] res_q, res_d;
    logic [LANES*4-1:0] flg_q, flg_d;
    logic [LANES-1:0]   dz_q, dz_d;

    logic [LANES*N-1:0] sc_res, st_dq, st_rm, fin_res, abs_a, abs_b;
    logic [LANES*4-1:0] sc_flg, fin_flg;
    logic [LANES-1:0]   fin_dz;
    logic               is_dm, accept;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [N-1:0]   la, lb, r, dq, rm, dv, ra, rb, qv, rv, fr;
        logic [N:0]     sum, dif, tr, ts;
        logic [2*N-1:0] ax, bx, prod;
        logic           c, v, qb, bz, ovf;

        assign la   = a[g*N +: N];
        assign lb   = b[g*N +: N];
        assign sum  = {1'b0, la} + {1'b0, lb};
        assign dif  = {1'b0, la} - {1'b0, lb};
        assign ax   = {{N{la[N-1]}}, la};
        assign bx   = {{N{lb[N-1]}}, lb};
        assign prod = ax * bx;

        always_comb begin
            r = '0;
            c = 1'b0;
            v = 1'b0;
            case (ctrl)
                OP_ADD: begin
                    r = sum[N-1:0];
                    c = sum[N];
                    v = (la[N-1] == lb[N-1]) && (sum[N-1] != la[N-1]);
`ifdef ALU_SAT_EN
                    if (v) r = la[N-1] ? MINV : MAXV;
`endif
                end
                OP_SUB: begin
                    r = dif[N-1:0];
                    c = dif[N];
                    v = (la[N-1] != lb[N-1]) && (dif[N-1] != la[N-1]);
`ifdef ALU_SAT_EN
                    if (v) r = la[N-1] ? MINV : MAXV;
`endif
                end
                OP_MUL: begin
                    r = prod[N-1:0];
                    // fits signed N bits iff the top N+1 bits agree
                    v = !((&prod[2*N-1:N-1]) || !(|prod[2*N-1:N-1]));
`ifdef ALU_SAT_EN
                    if (v) r = prod[2*N-1] ? MINV : MAXV;
`endif
                end
                OP_OR:   r = la | lb;
                OP_AND:  r = la & lb;
                OP_CPB:  r = lb;
                default: r = '0;
            endcase
        end

        assign sc_res[g*N +: N] = r;
        assign sc_flg[g*4 +: 4] = {r[N-1], r == '0, c, v};
        assign abs_a[g*N +: N]  = la[N-1] ? -la : la;
        assign abs_b[g*N +: N]  = lb[N-1] ? -lb : lb;

        // one restoring step: shift dividend MSB into the remainder
        assign dq = dq_q[g*N +: N];
        assign rm = rm_q[g*N +: N];
        assign dv = dv_q[g*N +: N];
        assign tr = {rm, dq[N-1]};
        assign ts = tr - {1'b0, dv};
        assign qb = ~ts[N];
        assign st_dq[g*N +: N] = {dq[N-2:0], qb};
        assign st_rm[g*N +: N] = qb ? ts[N-1:0] : tr[N-1:0];

        // sign fix-up after N steps; dq holds |q|, rm holds |r|
        assign ra  = a_q[g*N +: N];
        assign rb  = b_q[g*N +: N];
        assign qv  = (ra[N-1] ^ rb[N-1]) ? -dq : dq;
        assign rv  = ra[N-1] ? -rm : rm;
        assign bz  = (rb == '0);
        assign ovf = (ra == MINV) && (&rb);
        assign fr  = bz ? (div_q ? '1 : ra) : (div_q ? qv : rv);
        assign fin_res[g*N +: N] = fr;
        assign fin_flg[g*4 +: 4] = {fr[N-1], fr == '0, 1'b0, ovf};
        assign fin_dz[g] = bz;
    end

    assign is_dm     = (ctrl == OP_DIV) || (ctrl == OP_MOD);
    assign in_ready  = rst_n && ((state_q == IDLE) ||
                                 ((state_q == HOLD) && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == HOLD);
    assign result    = res_q;
    assign flags     = flg_q;
    assign dz        = dz_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        a_d     = a_q;
        b_d     = b_q;
        dq_d    = dq_q;
        rm_d    = rm_q;
        dv_d    = dv_q;
        res_d   = res_q;
        flg_d   = flg_q;
        dz_d    = dz_q;
        unique case (state_q)
            IDLE, HOLD: begin
                if (accept) begin
                    if (is_dm) begin
                        state_d = BUSY;
                        cnt_d   = CW'(N);
                        div_d   = (ctrl == OP_DIV);
                        a_d     = a;
                        b_d     = b;
                        dq_d    = abs_a;
                        dv_d    = abs_b;
                        rm_d    = '0;
                    end else begin
                        state_d = HOLD;
                        res_d   = sc_res;
                        flg_d   = sc_flg;
                        dz_d    = '0;
                    end
                end else if ((state_q == HOLD) && out_ready) begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = HOLD;
                    res_d   = fin_res;
                    flg_d   = fin_flg;
                    dz_d    = fin_dz;
                end else begin
                    dq_d  = st_dq;
                    rm_d  = st_rm;
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            dq_q    <= '0;
            rm_q    <= '0;
            dv_q    <= '0;
            res_q   <= '0;
            flg_q   <= '0;
            dz_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            a_q     <= a_d;
            b_q     <= b_d;
            dq_q    <= dq_d;
            rm_q    <= rm_d;
            dv_q    <= dv_d;
            res_q   <= res_d;
            flg_q   <= flg_d;
            dz_q    <= dz_d;
        end
    end
endmodule

// File: tb/tb_alu_simd_mc.sv
// tb_alu_simd_mc: directed checks of alu_simd_mc with N=8, LANES=4.
// Lane vectors are packed lane0 in the low byte.
module tb_alu_simd_mc;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, out_valid, out_ready;
    logic [3:0]  ctrl;
    logic [31:0] a, b, result;
    logic [15:0] flags;
    logic [3:0]  dz;
    int          tests = 0;
    int          fails = 0;
    int          cyc;

    alu_simd_mc #(.N(8), .LANES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .ctrl(ctrl), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags), .dz(dz)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pk(input logic [7:0] l0, input logic [7:0] l1,
                                       input logic [7:0] l2, input logic [7:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(input int budget);
        cyc = 0;
        while (!out_valid && cyc < budget) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        ctrl = 4'h0; a = '0; b = '0;
        tick(); tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_flags", flags, 0);
        check("rst_dz", dz, 0);
        check("rst_in_ready", in_ready, 0);
        rst_n = 1'b1;
        tick();
        check("idle_in_ready", in_ready, 1);

        // add with carry/overflow/zero lanes
        in_valid = 1'b1; ctrl = 4'h0;
        a = pk(8'h64, 8'hFF, 8'h7F, 8'h00);
        b = pk(8'h1B, 8'h01, 8'h01, 8'h00);
        tick();
        in_valid = 1'b0;
        check("add_valid", out_valid, 1);
`ifdef ALU_SAT_EN
        check("add_result", result, pk(8'h7F, 8'h00, 8'h7F, 8'h00));
        check("add_flags", flags, 16'h4160);
`else
        check("add_result", result, pk(8'h7F, 8'h00, 8'h80, 8'h00));
        check("add_flags", flags, 16'h4960);
`endif
        check("add_dz", dz, 0);
        tick();
        check("add_drain", out_valid, 0);

        // div, then inputs scrambled while busy
        in_valid = 1'b1; ctrl = 4'h8;
        a = pk(8'hF9, 8'h07, 8'h80, 8'h05);
        b = pk(8'h02, 8'hFE, 8'hFF, 8'h00);
        tick();
        in_valid = 1'b0; ctrl = 4'h0; a = '1; b = 32'h1234_5678;
        check("div_busy_ready", in_ready, 0);
        check("div_busy_valid", out_valid, 0);
        wait_out(20);
        check("div_latency", cyc, 9);
        check("div_result", result, pk(8'hFD, 8'hFD, 8'h80, 8'hFF));
        check("div_flags", flags, 16'h8988);
        check("div_dz", dz, 4'b1000);

        // mod issued straight from HOLD
        in_valid = 1'b1; ctrl = 4'h4;
        a = pk(8'hF9, 8'h07, 8'h80, 8'h05);
        b = pk(8'h02, 8'hFE, 8'hFF, 8'h00);
        tick();
        in_valid = 1'b0;
        wait_out(20);
        check("mod_latency", cyc, 9);
        check("mod_result", result, pk(8'hFF, 8'h01, 8'h00, 8'h05));
        check("mod_dz", dz, 4'b1000);
        tick();

        // mul under backpressure, sub waiting at the input
        out_ready = 1'b0; in_valid = 1'b1; ctrl = 4'h2;
        a = pk(8'h0A, 8'hFD, 8'h10, 8'h80);
        b = pk(8'h0C, 8'h05, 8'h10, 8'h01);
        tick();
        ctrl = 4'h1;
        a = pk(8'h05, 8'h00, 8'h80, 8'h9C);
        b = pk(8'h03, 8'h01, 8'h01, 8'h64);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
`ifdef ALU_SAT_EN
            check("bp_result", result, pk(8'h78, 8'hF1, 8'h7F, 8'h80));
            check("bp_flags", flags, 16'h8180);
`else
            check("bp_result", result, pk(8'h78, 8'hF1, 8'h00, 8'h80));
            check("bp_flags", flags, 16'h8580);
`endif
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1);
        tick();
        check("sub_valid", out_valid, 1);
`ifdef ALU_SAT_EN
        check("sub_result", result, pk(8'h02, 8'hFF, 8'h80, 8'h80));
        check("sub_flags", flags, 16'h99A0);
`else
        check("sub_result", result, pk(8'h02, 8'hFF, 8'h7F, 8'h38));
        check("sub_flags", flags, 16'h11A0);
`endif

        // back-to-back add/or/and/copy-b
        a = pk(8'h0F, 8'hF0, 8'h55, 8'h80);
        b = pk(8'h01, 8'h0F, 8'hAA, 8'h80);
        ctrl = 4'h0;
        tick();
        check("b2b_add_valid", out_valid, 1);
`ifdef ALU_SAT_EN
        check("b2b_add", result, pk(8'h10, 8'hFF, 8'hFF, 8'h80));
        check("b2b_add_flags", flags, 16'hB880);
`else
        check("b2b_add", result, pk(8'h10, 8'hFF, 8'hFF, 8'h00));
        check("b2b_add_flags", flags, 16'h7880);
`endif
        ctrl = 4'h3;
        tick();
        check("b2b_or", result, pk(8'h0F, 8'hFF, 8'hFF, 8'h80));
        check("b2b_or_flags", flags, 16'h8880);
        ctrl = 4'h5;
        tick();
        check("b2b_and", result, pk(8'h01, 8'h00, 8'h00, 8'h80));
        check("b2b_and_flags", flags, 16'h8440);
        ctrl = 4'h6;
        tick();
        check("b2b_cpb_valid", out_valid, 1);
        check("b2b_cpb", result, pk(8'h01, 8'h0F, 8'hAA, 8'h80));
        check("b2b_cpb_flags", flags, 16'h8800);

        // 100 + 100 saturates or wraps
        ctrl = 4'h0;
        a = pk(8'h64, 8'h00, 8'h00, 8'h00);
        b = pk(8'h64, 8'h00, 8'h00, 8'h00);
        tick();
`ifdef ALU_SAT_EN
        check("sat_add", result, pk(8'h7F, 8'h00, 8'h00, 8'h00));
        check("sat_add_flags", flags, 16'h4441);
`else
        check("wrap_add", result, pk(8'hC8, 8'h00, 8'h00, 8'h00));
        check("wrap_add_flags", flags, 16'h4449);
`endif

        // undefined opcode
        ctrl = 4'hF;
        a = pk(8'h12, 8'h34, 8'h56, 8'h78);
        b = pk(8'h9A, 8'hBC, 8'hDE, 8'hF0);
        tick();
        check("undef_result", result, 0);
        check("undef_flags", flags, 16'h4444);
        check("undef_dz", dz, 0);
        in_valid = 1'b0;
        tick();

        // reset during a division
        in_valid = 1'b1; ctrl = 4'h8;
        a = pk(8'h40, 8'h40, 8'h40, 8'h40);
        b = pk(8'h03, 8'h03, 8'h03, 8'h03);
        tick();
        in_valid = 1'b0;
        tick(); tick();
        rst_n = 1'b0;
        tick();
        check("rstdiv_valid", out_valid, 0);
        check("rstdiv_result", result, 0);
        check("rstdiv_in_ready", in_ready, 0);
        rst_n = 1'b1;
        tick();
        check("rstdiv_ready", in_ready, 1);
        repeat (12) tick();
        check("rstdiv_no_out", out_valid, 0);
        in_valid = 1'b1; ctrl = 4'h0;
        a = pk(8'h01, 8'h02, 8'h03, 8'h04);
        b = pk(8'h01, 8'h01, 8'h01, 8'h01);
        tick();
        in_valid = 1'b0;
        check("post_rst_valid", out_valid, 1);
        check("post_rst_add", result, pk(8'h02, 8'h03, 8'h04, 8'h05));
        check("post_rst_flags", flags, 16'h0000);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
